// File: rtl/task_dispatcher.sv
// task_dispatcher: runtime sequencer for a ranked, processor-assigned task graph.
// Dispatches over start/done handshakes, reports makespan, flags bad schedules.
module task_dispatcher #(
    parameter int NUM_TASKS      = 10,
    parameter int NUM_PROCESSORS = 3,
    parameter int TASK_W         = 4,
    parameter int PROC_W         = 3,
    parameter int LVL_W          = 3,
    parameter int CNT_W          = 32
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             start,
    input  logic [NUM_TASKS*TASK_W-1:0]      order_in,
    input  logic [NUM_TASKS*PROC_W-1:0]      assign_in,
    input  logic [NUM_TASKS*NUM_TASKS-1:0]   pred_in,
    input  logic [NUM_TASKS*LVL_W-1:0]       lvl_in,
    output logic [NUM_PROCESSORS-1:0]        proc_start,
    output logic [NUM_PROCESSORS*TASK_W-1:0] proc_task,
    output logic [NUM_PROCESSORS*LVL_W-1:0]  proc_lvl,
    input  logic [NUM_PROCESSORS-1:0]        proc_done,
    output logic                             busy,
    output logic                             done,
    output logic                             error,
    output logic [CNT_W-1:0]                 makespan
);
    localparam int N = NUM_TASKS;
    localparam int P = NUM_PROCESSORS;

    typedef enum logic [1:0] {IDLE, LOAD, RUN, DONE} state_t;

    state_t                state_q, state_d;
    logic [TASK_W-1:0]     order_q [N];
    logic [TASK_W-1:0]     order_d [N];
    logic [PROC_W-1:0]     asg_q [N];
    logic [PROC_W-1:0]     asg_d [N];
    logic [LVL_W-1:0]      lvl_q [N];
    logic [LVL_W-1:0]      lvl_d [N];
    logic [N*N-1:0]        pred_q, pred_d;
    logic [N-1:0]          disp_q, disp_d;
    logic [N-1:0]          cmpl_q, cmpl_d;
    logic [N-1:0]          cur_q [P];
    logic [N-1:0]          cur_d [P];
    logic [P-1:0]          pbusy_q, pbusy_d;
    logic [P-1:0]          start_q, start_d;
    logic [P*TASK_W-1:0]   task_q, task_d;
    logic [P*LVL_W-1:0]    plvl_q, plvl_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  err_q, err_d;
    logic [CNT_W-1:0]      ms_q, ms_d;

    logic [N-1:0]          head_oh [P];
    logic [P-1:0]          head_ok;
    logic                  bad;

    // Head = first undispatched task of p in rank order; it alone may go.
    always_comb begin
        logic         found;
        logic [N-1:0] cand;
        logic [N-1:0] need;
        found   = 1'b0;
        cand    = '0;
        need    = '0;
        head_ok = '0;
        for (int p = 0; p < P; p++) begin
            head_oh[p] = '0;
            found      = 1'b0;
            for (int k = 0; k < N; k++) begin
                cand = '0;
                for (int t = 0; t < N; t++) begin
                    if (order_q[k] == TASK_W'(t) && asg_q[t] == PROC_W'(p)
                        && !disp_q[t])
                        cand[t] = 1'b1;
                end
                if (!found && cand != '0) begin
                    head_oh[p] = cand;
                    found      = 1'b1;
                end
            end
            need = '0;
            for (int t = 0; t < N; t++) begin
                for (int i = 0; i < N; i++) begin
                    if (head_oh[p][t] && pred_q[i*N+t])
                        need[i] = 1'b1;
                end
            end
            head_ok[p] = found && !pbusy_q[p] && ((need & ~cmpl_q) == '0);
        end
    end

    always_comb begin
        state_d = state_q;
        order_d = order_q;
        asg_d   = asg_q;
        lvl_d   = lvl_q;
        pred_d  = pred_q;
        disp_d  = disp_q;
        cmpl_d  = cmpl_q;
        cur_d   = cur_q;
        pbusy_d = pbusy_q;
        start_d = '0;
        task_d  = task_q;
        plvl_d  = plvl_q;
        err_d   = err_q;
        ms_d    = ms_q;
        bad     = 1'b0;
        unique case (state_q)
            IDLE, DONE: begin
                if (start) begin
                    state_d = LOAD;
                    err_d   = 1'b0;
                end
            end
            LOAD: begin
                pred_d = pred_in;
                for (int t = 0; t < N; t++) begin
                    order_d[t] = order_in[t*TASK_W +: TASK_W];
                    asg_d[t]   = assign_in[t*PROC_W +: PROC_W];
                    lvl_d[t]   = lvl_in[t*LVL_W +: LVL_W];
                    if (int'(order_in[t*TASK_W +: TASK_W]) >= N ||
                        int'(assign_in[t*PROC_W +: PROC_W]) >= P)
                        bad = 1'b1;
                end
                if (bad) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end else begin
                    state_d = RUN;
                    ms_d    = '0;
                    disp_d  = '0;
                    cmpl_d  = '0;
                    pbusy_d = '0;
                end
            end
            RUN: begin
                ms_d = ms_q + 1'b1;
                for (int p = 0; p < P; p++) begin
                    if (proc_done[p] && pbusy_q[p]) begin
                        cmpl_d     = cmpl_d | cur_q[p];
                        pbusy_d[p] = 1'b0;
                    end
                    if (head_ok[p]) begin
                        start_d[p] = 1'b1;
                        pbusy_d[p] = 1'b1;
                        disp_d     = disp_d | head_oh[p];
                        cur_d[p]   = head_oh[p];
                        for (int t = 0; t < N; t++) begin
                            if (head_oh[p][t]) begin
                                task_d[p*TASK_W +: TASK_W] = TASK_W'(t);
                                plvl_d[p*LVL_W +: LVL_W]   = lvl_q[t];
                            end
                        end
                    end
                end
                // Success looks at the updated vector; deadlock at registered state.
                if (&cmpl_d) begin
                    state_d = DONE;
                    err_d   = 1'b0;
                end else if (pbusy_q == '0 && head_ok == '0) begin
                    state_d = DONE;
                    err_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d == LOAD) || (state_d == RUN);
        done_d = (state_d == DONE);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            order_q <= '{default: '0};
            asg_q   <= '{default: '0};
            lvl_q   <= '{default: '0};
            pred_q  <= '0;
            disp_q  <= '0;
            cmpl_q  <= '0;
            cur_q   <= '{default: '0};
            pbusy_q <= '0;
            start_q <= '0;
            task_q  <= '0;
            plvl_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            ms_q    <= '0;
        end else begin
            state_q <= state_d;
            order_q <= order_d;
            asg_q   <= asg_d;
            lvl_q   <= lvl_d;
            pred_q  <= pred_d;
            disp_q  <= disp_d;
            cmpl_q  <= cmpl_d;
            cur_q   <= cur_d;
            pbusy_q <= pbusy_d;
            start_q <= start_d;
            task_q  <= task_d;
            plvl_q  <= plvl_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            ms_q    <= ms_d;
        end
    end

    assign proc_start = start_q;
    assign proc_task  = task_q;
    assign proc_lvl   = plvl_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign error      = err_q;
    assign makespan   = ms_q;

endmodule
